// File: rtl/vending_pkg.sv
// Shared types and defaults for the vending transaction controller and its front end.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE
  } state_e;

  localparam int PRICE_W_DEF = 4;
  localparam int QTY_W_DEF   = 4;

  function automatic int idx_w(input int n_items);
    return (n_items <= 1) ? 1 : $clog2(n_items);
  endfunction

endpackage

// File: rtl/vending_inventory.sv
// Per-item price and stock tables: saturating config write, combinational read, purchase decrement.
module vending_inventory
  import vending_pkg::*;
#(
  parameter int N_ITEMS   = 8,
  parameter int PRICE_W   = PRICE_W_DEF,
  parameter int QTY_W     = QTY_W_DEF,
  parameter int PRICE_RST = 1,
  parameter int STOCK_RST = 4,
  parameter int IDX_W     = idx_w(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [PRICE_W-1:0] cfg_price,
  input  logic [QTY_W-1:0]   cfg_add,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_hit,
  output logic [PRICE_W-1:0] rd_price,
  output logic [QTY_W-1:0]   rd_stock,
  input  logic               dec_en,
  input  logic [QTY_W-1:0]   dec_qty
);

  logic [PRICE_W-1:0] price_q [N_ITEMS];
  logic [PRICE_W-1:0] price_d [N_ITEMS];
  logic [QTY_W-1:0]   stock_q [N_ITEMS];
  logic [QTY_W-1:0]   stock_d [N_ITEMS];
  logic [QTY_W:0]     sat_sum [N_ITEMS];

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      sat_sum[i] = {1'b0, stock_q[i]} + {1'b0, cfg_add};
    end
  end

  // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      price_d[i] = price_q[i];
      stock_d[i] = stock_q[i];
      if (cfg_we && int'(cfg_idx) == i) begin
        price_d[i] = cfg_price;
        stock_d[i] = sat_sum[i][QTY_W] ? '1 : sat_sum[i][QTY_W-1:0];
      end
      if (dec_en && int'(rd_idx) == i) begin
        stock_d[i] = stock_q[i] - dec_qty;
      end
    end
  end

  // NOTE: these tables are plain flops with a defined power-on content, so they are reset;
  // a RAM-backed table would not be.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge values.
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        price_q[i] <= PRICE_W'(PRICE_RST);
        stock_q[i] <= QTY_W'(STOCK_RST);
      end
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        price_q[i] <= price_d[i];
        stock_q[i] <= stock_d[i];
      end
    end
  end

  assign rd_hit   = int'(rd_idx) < N_ITEMS;
  assign rd_price = rd_hit ? price_q[rd_idx] : '0;
  assign rd_stock = rd_hit ? stock_q[rd_idx] : '0;

endmodule

// File: rtl/vending_txn_ctrl.sv
// Vending purchase controller: credit, select/check/dispense/change FSM, machine account.
// Optional idle-credit auto refund is built when VEND_TIMEOUT_EN is defined.
module vending_txn_ctrl
  import vending_pkg::*;
#(
  parameter int N_ITEMS     = 8,
  parameter int PRICE_W     = PRICE_W_DEF,
  parameter int QTY_W       = QTY_W_DEF,
  parameter int CREDIT_W    = 8,
  parameter int ACC_W       = 16,
  parameter int PRICE_RST   = 1,
  parameter int STOCK_RST   = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = idx_w(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [PRICE_W-1:0]  coin_value,
  output logic                coin_reject,
  input  logic                sel_valid,
  output logic                sel_ready,
  input  logic [IDX_W-1:0]    sel_item,
  input  logic [QTY_W-1:0]    sel_qty,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [PRICE_W-1:0]  cfg_price,
  input  logic [QTY_W-1:0]    cfg_add,
  output logic                disp_valid,
  output logic [IDX_W-1:0]    disp_item,
  output logic [QTY_W-1:0]    disp_qty,
  input  logic                disp_ack,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_amount,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [ACC_W-1:0]    machine_acc,
  output logic                red_light,
  output logic                busy
);

  localparam int COST_W = PRICE_W + QTY_W;
  localparam int CMP_W  = (COST_W > CREDIT_W) ? COST_W : CREDIT_W;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    item_q, item_d;
  logic [QTY_W-1:0]    qty_q, qty_d;
  logic                red_q, red_d;
  logic                coin_reject_q, coin_reject_d;
  logic                disp_valid_q, chg_valid_q, sel_ready_q, busy_q;

  logic                accepting, coin_ok, check_ok, dec_en, tmo_hit;
  logic [CREDIT_W:0]   coin_sum;
  logic [COST_W-1:0]   cost;
  logic                rd_hit;
  logic [PRICE_W-1:0]  rd_price;
  logic [QTY_W-1:0]    rd_stock;

  vending_inventory #(
    .N_ITEMS  (N_ITEMS),
    .PRICE_W  (PRICE_W),
    .QTY_W    (QTY_W),
    .PRICE_RST(PRICE_RST),
    .STOCK_RST(STOCK_RST),
    .IDX_W    (IDX_W)
  ) u_inventory (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we && accepting),
    .cfg_idx  (cfg_idx),
    .cfg_price(cfg_price),
    .cfg_add  (cfg_add),
    .rd_idx   (item_q),
    .rd_hit   (rd_hit),
    .rd_price (rd_price),
    .rd_stock (rd_stock),
    .dec_en   (dec_en),
    .dec_qty  (qty_q)
  );

  assign accepting = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
  assign coin_sum  = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value);
  assign coin_ok   = coin_valid && accepting && !coin_sum[CREDIT_W];
  assign cost      = COST_W'(rd_price) * COST_W'(qty_q);
  assign check_ok  = rd_hit && (qty_q != '0) && (qty_q <= rd_stock)
                  && (CMP_W'(cost) <= CMP_W'(credit_q));

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts only idle CREDIT cycles; any accepted coin or selection restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_CREDIT && !coin_ok && !sel_valid) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  assign tmo_hit = (state_q == ST_CREDIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) && !coin_ok;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    acc_d         = acc_q;
    item_d        = item_q;
    qty_d         = qty_q;
    red_d         = red_q;
    dec_en        = 1'b0;
    coin_reject_d = coin_valid && !coin_ok;
    if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];

    unique case (state_q)
      ST_IDLE: if (coin_ok) state_d = ST_CREDIT;
      ST_CREDIT: begin
        if (cancel) begin
          state_d = ST_CHANGE;
        end else if (sel_valid) begin
          item_d  = sel_item;
          qty_d   = sel_qty;
          state_d = ST_CHECK;
        end else if (tmo_hit) begin
          state_d = ST_CHANGE;
        end
      end
      ST_CHECK: begin
        if (check_ok) begin
          dec_en   = 1'b1;
          credit_d = credit_q - CREDIT_W'(cost);
          acc_d    = acc_q + ACC_W'(cost);
          red_d    = 1'b0;
          state_d  = ST_DISPENSE;
        end else begin
          red_d   = 1'b1;
          state_d = ST_CREDIT;
        end
      end
      ST_DISPENSE: if (disp_ack) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: begin
        if (chg_ack) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) red_d = 1'b0;
  end

  // Handshake outputs are registered from the next state so they change cleanly with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      acc_q         <= '0;
      item_q        <= '0;
      qty_q         <= '0;
      red_q         <= 1'b0;
      coin_reject_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      chg_valid_q   <= 1'b0;
      sel_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      acc_q         <= acc_d;
      item_q        <= item_d;
      qty_q         <= qty_d;
      red_q         <= red_d;
      coin_reject_q <= coin_reject_d;
      disp_valid_q  <= (state_d == ST_DISPENSE);
      chg_valid_q   <= (state_d == ST_CHANGE);
      sel_ready_q   <= (state_d == ST_CREDIT);
      busy_q        <= (state_d == ST_CHECK) || (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end
  end

  assign coin_reject = coin_reject_q;
  assign sel_ready   = sel_ready_q;
  assign disp_valid  = disp_valid_q;
  assign disp_item   = item_q;
  assign disp_qty    = qty_q;
  assign chg_valid   = chg_valid_q;
  assign chg_amount  = credit_q;
  assign credit      = credit_q;
  assign machine_acc = acc_q;
  assign red_light   = red_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// Directed self-checking bench for vending_txn_ctrl (default build, macro undefined).
module tb_vending_txn_ctrl;

  localparam int IDX_W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         coin_valid;
  logic [3:0]   coin_value;
  logic         coin_reject;
  logic         sel_valid;
  logic         sel_ready;
  logic [IDX_W-1:0] sel_item;
  logic [3:0]   sel_qty;
  logic         cancel;
  logic         cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [3:0]   cfg_price;
  logic [3:0]   cfg_add;
  logic         disp_valid;
  logic [IDX_W-1:0] disp_item;
  logic [3:0]   disp_qty;
  logic         disp_ack;
  logic         chg_valid;
  logic [7:0]   chg_amount;
  logic         chg_ack;
  logic [7:0]   credit;
  logic [15:0]  machine_acc;
  logic         red_light;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  vending_txn_ctrl dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_item(sel_item), .sel_qty(sel_qty),
    .cancel(cancel),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_price(cfg_price), .cfg_add(cfg_add),
    .disp_valid(disp_valid), .disp_item(disp_item), .disp_qty(disp_qty), .disp_ack(disp_ack),
    .chg_valid(chg_valid), .chg_amount(chg_amount), .chg_ack(chg_ack),
    .credit(credit), .machine_acc(machine_acc), .red_light(red_light), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [IDX_W-1:0] item, input logic [3:0] qty);
    sel_item  = item;
    sel_qty   = qty;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [IDX_W-1:0] idx, input logic [3:0] price, input logic [3:0] add);
    cfg_idx   = idx;
    cfg_price = price;
    cfg_add   = add;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_disp_ack();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  task automatic pulse_chg_ack();
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0; coin_value = '0;
    sel_valid = 1'b0; sel_item = '0; sel_qty = '0;
    cancel = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_price = '0; cfg_add = '0;
    disp_ack = 1'b0; chg_ack = 1'b0;
    tick();
    tick();
    check("rst_credit", credit, 0);
    check("rst_acc", machine_acc, 0);
    check("rst_red", red_light, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_chg_valid", chg_valid, 0);
    check("rst_coin_reject", coin_reject, 0);
    rst = 1'b0;
    tick();
    check("idle_sel_ready", sel_ready, 0);
    check("idle_busy", busy, 0);

    // Basic purchase: 5+3, item 2 x2 at price 1
    coin(4'd5);
    coin(4'd3);
    check("p1_credit", credit, 8);
    check("p1_sel_ready", sel_ready, 1);
    sel_item = 3'd2; sel_qty = 4'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    check("p1_check_busy", busy, 1);
    check("p1_check_sel_ready", sel_ready, 0);
    tick();
    check("p1_disp_valid", disp_valid, 1);
    check("p1_disp_item", disp_item, 2);
    check("p1_disp_qty", disp_qty, 2);
    check("p1_credit_after", credit, 6);
    check("p1_acc", machine_acc, 2);
    cfg(3'd0, 4'd15, 4'd0);  // ignored while dispensing
    check("p1_disp_hold", disp_valid, 1);
    pulse_disp_ack();
    check("p1_disp_done", disp_valid, 0);
    check("p1_chg_valid", chg_valid, 1);
    check("p1_chg_amount", chg_amount, 6);
    pulse_chg_ack();
    check("p1_chg_done", chg_valid, 0);
    check("p1_credit_zero", credit, 0);
    check("p1_idle_busy", busy, 0);

    // Item 2 now has stock 2: qty 3 is refused, then cancel refunds
    coin(4'd3);
    select(3'd2, 4'd3);
    check("stock2_red", red_light, 1);
    check("stock2_credit", credit, 3);
    check("stock2_sel_ready", sel_ready, 1);
    check("stock2_acc", machine_acc, 2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_chg_valid", chg_valid, 1);
    check("cancel_chg_amount", chg_amount, 3);
    check("cancel_no_disp", disp_valid, 0);
    pulse_chg_ack();
    check("idle_clears_red", red_light, 0);

    // Price 7 on item 1: cost 14 > 10 refused, cost 7 accepted
    cfg(3'd1, 4'd7, 4'd0);
    coin(4'd10);
    select(3'd1, 4'd2);
    check("price_red", red_light, 1);
    check("price_credit_kept", credit, 10);
    check("price_in_credit", sel_ready, 1);
    select(3'd1, 4'd1);
    check("price_ok_red", red_light, 0);
    check("price_ok_disp", disp_valid, 1);
    check("price_ok_credit", credit, 3);
    check("price_ok_acc", machine_acc, 9);
    pulse_disp_ack();
    check("price_chg_amount", chg_amount, 3);
    pulse_chg_ack();

    // Stock 4 refuses qty 5; +15 saturates to 15 so qty 15 succeeds
    coin(4'd15);
    select(3'd3, 4'd5);
    check("qty5_red", red_light, 1);
    check("qty5_credit", credit, 15);
    cfg(3'd3, 4'd1, 4'd15);
    select(3'd3, 4'd15);
    check("sat_disp", disp_valid, 1);
    check("sat_disp_qty", disp_qty, 15);
    check("sat_credit", credit, 0);
    check("sat_acc", machine_acc, 24);
    pulse_disp_ack();
    check("zero_credit_no_chg", chg_valid, 0);
    check("zero_credit_idle", busy, 0);
    coin(4'd1);
    select(3'd3, 4'd1);
    check("empty_red", red_light, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("empty_chg_amount", chg_amount, 1);
    pulse_chg_ack();

    // Credit overflow boundary
    repeat (16) coin(4'd15);
    coin(4'd10);
    check("c250_credit", credit, 250);
    coin(4'd9);
    check("ovf_reject", coin_reject, 1);
    check("ovf_credit", credit, 250);
    tick();
    check("ovf_pulse_end", coin_reject, 0);
    coin(4'd5);
    check("c255_credit", credit, 255);
    check("c255_no_reject", coin_reject, 0);
    select(3'd0, 4'd1);
    check("p0_disp", disp_valid, 1);
    check("p0_credit", credit, 254);
    check("p0_acc", machine_acc, 25);
    coin(4'd4);
    check("disp_coin_reject", coin_reject, 1);
    check("disp_coin_credit", credit, 254);

    // Reset in DISPENSE aborts everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_credit", credit, 0);
    check("mid_rst_acc", machine_acc, 0);
    check("mid_rst_disp", disp_valid, 0);
    check("mid_rst_chg", chg_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_coin_reject", coin_reject, 0);
    check("mid_rst_sel_ready", sel_ready, 0);
    coin(4'd4);
    select(3'd3, 4'd4);
    check("rst_stock_disp", disp_valid, 1);
    check("rst_stock_acc", machine_acc, 4);
    pulse_disp_ack();

    // Cancel beats a simultaneous selection
    coin(4'd6);
    sel_item = 3'd0; sel_qty = 4'd1; sel_valid = 1'b1; cancel = 1'b1;
    tick();
    sel_valid = 1'b0; cancel = 1'b0;
    check("cs_chg_valid", chg_valid, 1);
    check("cs_chg_amount", chg_amount, 6);
    check("cs_no_disp", disp_valid, 0);
    pulse_chg_ack();
    check("cs_acc", machine_acc, 4);

    // Credit waits indefinitely without the timeout feature
    coin(4'd4);
    repeat (100) tick();
    check("wait_sel_ready", sel_ready, 1);
    check("wait_chg_valid", chg_valid, 0);
    check("wait_credit", credit, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
